uram_stream_reader: RTL and testbench
=====================================

// Module: uram_stream_reader
// PURPOSE
//  Read-side controller for the double-pumped URAM (uram_wrapper). Accepts a (base, length) read command,
//  issues one URAM read per cycle on the read port, absorbs the fixed URAM read latency, and delivers the
//  entries in address order on a valid/ready stream with o_last. Runs in the clk2x domain next to the URAM.
// PARAMETERS
//  DATA_WIDTH  64                  entry width in bits; equals the URAM DATA_WIDTH
//  RAM_DEPTH   4096                URAM entries; addresses wrap modulo RAM_DEPTH
//  ADDR_WIDTH  $clog2(RAM_DEPTH)   URAM address width
//  RD_LATENCY  2                   cycles from o_re high to valid i_rd; must match the URAM configuration
//  FIFO_DEPTH  4                   output FIFO entries; power of 2, >= RD_LATENCY+2
// PORTS
//  clk2x         in   1             single clock for the whole block
//  reset         in   1             synchronous, active-low reset
//  i_cmd_valid   in   1             read command valid
//  o_cmd_ready   out  1             command accepted when both valid and ready are high
//  i_cmd_base    in   ADDR_WIDTH    first URAM address to read
//  i_cmd_len     in   ADDR_WIDTH+1  number of entries, 0..RAM_DEPTH
//  o_re          out  1             URAM read enable; drives i_re on uram_wrapper
//  o_ra          out  ADDR_WIDTH    URAM read address; drives i_ra on uram_wrapper
//  i_rd          in   DATA_WIDTH    URAM read data; from o_rd on uram_wrapper
//  o_valid       out  1             output entry valid
//  i_ready       in   1             consumer ready; an entry transfers when both are high
//  o_data        out  DATA_WIDTH    output entry
//  o_last        out  1             high with the final entry of a command
//  o_busy        out  1             a command is in progress (state is not IDLE)
// BEHAVIOUR
//  Reset (reset==0 at a clk2x edge)
//   - o_cmd_ready=0, o_re=0, o_ra=0, o_valid=0, o_last=0, o_busy=0, o_data=0.
//   - FIFO is emptied, the in-flight valid shift register is cleared, state goes to IDLE.
//   - A reset mid-command aborts the command. URAM data still in flight after reset is ignored.
//  FSM: IDLE -> ISSUE -> DRAIN -> IDLE
//   - IDLE: o_cmd_ready=1. On handshake, latch base/len into ra_q/remain.
//     len==0: stay in IDLE; no reads and no output. Otherwise go to ISSUE.
//   - ISSUE: o_re = credit_ok, where credit_ok = (inflight + fifo_count) < FIFO_DEPTH.
//     When o_re=1: o_ra=ra_q, then ra_q <= ra_q+1 (wraps RAM_DEPTH-1 -> 0) and remain <= remain-1.
//     After the read with remain==1 is issued, go to DRAIN.
//   - DRAIN: o_re=0. When the entry carrying o_last transfers, go to IDLE.
//     o_cmd_ready stays 0 in DRAIN; it returns to 1 in the cycle after that transfer.
//  Latency pipeline
//   - A valid shift register of length RD_LATENCY carries o_re.
//   - Its tail qualifies i_rd; the qualified data is written into the FIFO in that cycle.
//   - A last bit (remain==1 at issue) travels alongside and is stored with each entry.
//   - inflight = popcount of the shift register, RD_LATENCY+1 bits wide.
//  Timing
//   - Command handshake in cycle C: first o_re in C+1, i_rd sampled in C+1+RD_LATENCY, o_valid=1 in C+2+RD_LATENCY.
//   - With i_ready held high, the block sustains one entry per cycle with no bubbles.
//  Output stream
//   - o_valid = !fifo_empty; o_data and o_last come from the FIFO head.
//   - Once o_valid is high, it and o_data/o_last stay stable until the transfer.
//   - Credit accounting guarantees the FIFO never overflows. Asserted in simulation: no write while full.
//  Simultaneous events
//   - FIFO push and pop in the same cycle: fifo_count is unchanged.
//   - A pop frees credit for the next cycle's issue decision only; credit_ok uses registered counts.
//  Boundaries
//   - i_cmd_len==RAM_DEPTH reads every entry once, starting at base and wrapping.
//   - A base near the top of the address space wraps to 0.
//  Widths
//   - remain and i_cmd_len are ADDR_WIDTH+1 bits.
//   - fifo_count is $clog2(FIFO_DEPTH)+1 bits.
// STRUCTURE
//  Package uram_pkg
//   - typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_t.
//   - localparam URAM_RD_LATENCY = 2, shared with uram_wrapper.
//  Sub-module uram_rd_fifo
//   - Synchronous FIFO, FIFO_DEPTH x (DATA_WIDTH+1) bits.
//   - Combinational head read, count output, same-cycle push/pop.
//  Top level: FSM, address/remain counters, latency shift register, credit logic.
// TESTING (bench models uram_wrapper at RD_LATENCY=2, pre-loaded with mem[a]=a)
//  1. base=0x010, len=8, i_ready=1:
//     o_data 0x010..0x017 on 8 consecutive cycles; o_last only on 0x017; first o_valid in C+4.
//  2. base=0xFFE, len=4:
//     o_ra sequence 0xFFE, 0xFFF, 0x000, 0x001; same values on o_data; o_last on 0x001.
//  3. len=64 with i_ready randomly toggled ~50%:
//     all 64 entries in order, none lost or duplicated; never more than FIFO_DEPTH outstanding; no overflow assert.
//  4. len=0:
//     no o_re pulse, no o_valid, o_cmd_ready high again in the next cycle.
//  5. reset=0 for 1 cycle while 3 reads are in flight:
//     o_valid=0 afterwards, stale i_rd is not output, a new command (base=0x100, len=2) yields exactly 0x100, 0x101.
//  6. len=4096, base=0x800:
//     4096 transfers covering every address exactly once; o_last only on 0x7FF.

Source files
------------

// File: rtl/uram_pkg.sv
// Shared definitions for the URAM read path: reader FSM states and the
// URAM read latency that must match the uram_wrapper configuration.
package uram_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

    localparam int URAM_RD_LATENCY = 2;

endpackage : uram_pkg

// File: rtl/uram_rd_fifo.sv
// Small synchronous FIFO that buffers URAM read data ahead of the output
// stream. Head entry is read combinationally; push and pop may coincide.
module uram_rd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             full;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array: written on push, never reset.
    // NOTE: the data array carries no reset; only pointers and count are cleared, so it maps to plain RAM/LUTRAM.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // Credit accounting upstream must keep writes away from a full FIFO.
            if (push_i) begin
                assert (!full);
            end
        end
    end

endmodule : uram_rd_fifo

// File: rtl/uram_stream_reader.sv
// Read-side controller for the double-pumped URAM: turns a (base, length)
// command into one URAM read per cycle, absorbs the read latency and streams
// the entries out in address order with o_last on the final one.
module uram_stream_reader
    import uram_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int RAM_DEPTH  = 4096,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
    parameter int RD_LATENCY = URAM_RD_LATENCY,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk2x,
    input  logic                  reset,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0] i_cmd_base,
    input  logic [ADDR_WIDTH:0]   i_cmd_len,
    output logic                  o_re,
    output logic [ADDR_WIDTH-1:0] o_ra,
    input  logic [DATA_WIDTH-1:0] i_rd,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    output logic                  o_busy
);

    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int INF_W = RD_LATENCY + 1;
    localparam int SUM_W = INF_W + CNT_W;

    rd_state_t             state_q;
    logic [ADDR_WIDTH-1:0] ra_q;
    logic [LEN_W-1:0]      remain_q;
    logic                  cmd_ready_q;
    logic [RD_LATENCY-1:0] vld_sr_q;
    logic [RD_LATENCY-1:0] last_sr_q;

    logic                  cmd_fire;
    logic                  credit_ok;
    logic                  re;
    logic                  pop;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [DATA_WIDTH:0]   fifo_head;
    logic [INF_W-1:0]      inflight;
    logic [SUM_W-1:0]      credit_sum;
    logic [ADDR_WIDTH-1:0] ra_next;

    assign cmd_fire   = i_cmd_valid && cmd_ready_q;
    assign credit_sum = SUM_W'(inflight) + SUM_W'(fifo_count);
    assign credit_ok  = credit_sum < SUM_W'(FIFO_DEPTH);
    assign re         = (state_q == ISSUE) && credit_ok;
    assign pop        = o_valid && i_ready;
    assign ra_next    = (ra_q == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : ra_q + 1'b1;

    assign o_cmd_ready = cmd_ready_q;
    assign o_re        = re;
    assign o_ra        = ra_q;
    assign o_busy      = (state_q != IDLE);
    assign o_valid     = !fifo_empty;
    assign o_data      = o_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
    assign o_last      = o_valid && fifo_head[DATA_WIDTH];

    // Count reads still travelling through the URAM pipeline.
    // NOTE: the default assignment ahead of the loop keeps this purely combinational (no latch).
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + INF_W'(vld_sr_q[i]);
        end
    end

    // Command FSM with the address and remaining-count registers.
    always_ff @(posedge clk2x) begin
        if (!reset) begin
            state_q     <= IDLE;
            ra_q        <= '0;
            remain_q    <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_fire) begin
                        ra_q     <= i_cmd_base;
                        remain_q <= i_cmd_len;
                        if (i_cmd_len != '0) begin
                            state_q     <= ISSUE;
                            cmd_ready_q <= 1'b0;
                        end
                    end
                end
                ISSUE: begin
                    if (re) begin
                        ra_q     <= ra_next;
                        remain_q <= remain_q - 1'b1;
                        if (remain_q == LEN_W'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && fifo_head[DATA_WIDTH]) begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Valid and last bits follow each read through the fixed URAM latency.
    always_ff @(posedge clk2x) begin
        if (!reset) begin
            vld_sr_q  <= '0;
            last_sr_q <= '0;
        end else begin
            vld_sr_q[0]  <= re;
            last_sr_q[0] <= re && (remain_q == LEN_W'(1));
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_sr_q[i]  <= vld_sr_q[i-1];
                last_sr_q[i] <= last_sr_q[i-1];
            end
        end
    end

    uram_rd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk_i   (clk2x),
        .rst_ni  (reset),
        .push_i  (vld_sr_q[RD_LATENCY-1]),
        .wdata_i ({last_sr_q[RD_LATENCY-1], i_rd}),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule : uram_stream_reader

// File: tb/tb_uram_stream_reader.sv
// Self-checking bench for uram_stream_reader with a latency-2 URAM model
// holding mem[a] = a and a scoreboard of expected output entries.
module tb_uram_stream_reader;

    localparam int DW    = 64;
    localparam int DEPTH = 4096;
    localparam int AW    = 12;
    localparam int FD    = 4;

    logic          clk2x = 1'b0;
    logic          reset = 1'b0;
    logic          i_cmd_valid = 1'b0;
    logic          o_cmd_ready;
    logic [AW-1:0] i_cmd_base = '0;
    logic [AW:0]   i_cmd_len = '0;
    logic          o_re;
    logic [AW-1:0] o_ra;
    logic [DW-1:0] i_rd;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic [DW-1:0] o_data;
    logic          o_last;
    logic          o_busy;

    always #5 clk2x = ~clk2x;

    uram_stream_reader #(
        .DATA_WIDTH (DW),
        .RAM_DEPTH  (DEPTH),
        .RD_LATENCY (2),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk2x       (clk2x),
        .reset       (reset),
        .i_cmd_valid (i_cmd_valid),
        .o_cmd_ready (o_cmd_ready),
        .i_cmd_base  (i_cmd_base),
        .i_cmd_len   (i_cmd_len),
        .o_re        (o_re),
        .o_ra        (o_ra),
        .i_rd        (i_rd),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data      (o_data),
        .o_last      (o_last),
        .o_busy      (o_busy)
    );

    // URAM model: address registered twice, data = address (mem[a] = a).
    logic [AW-1:0] ra_d1 = '0;
    logic [AW-1:0] ra_d2 = '0;
    always @(posedge clk2x) begin
        ra_d1 <= o_ra;
        ra_d2 <= ra_d1;
    end
    assign i_rd = DW'(ra_d2);

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            cmd_cyc = 0;
    int            first_valid_cyc = -1;
    int            first_xfer_cyc = -1;
    int            last_xfer_cyc = -1;
    int            xfer_cnt = 0;
    int            outstanding = 0;
    logic [AW-1:0] exp_ra = '0;
    bit            hold_pending = 1'b0;
    logic [DW:0]   held = '0;
    logic [DW:0]   exp_q[$];

    task automatic check(input string tag, input logic [DW:0] obs, input logic [DW:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fail(input string tag);
        n_cmp++;
        n_err++;
        $error("FAIL %s: observed event not expected", tag);
    endtask

    // One clock: evaluate outputs at this falling edge, then advance.
    task automatic cycle();
        logic [DW:0] obs;
        obs = {o_last, o_data};
        if (hold_pending) begin
            check("hold_valid", DW'(o_valid), 1);
            check("hold_data", obs, held);
        end
        if (o_re === 1'b1) begin
            check("o_ra", DW'(o_ra), DW'(exp_ra));
            exp_ra = exp_ra + 1'b1;
            outstanding++;
            check("credit_bound", DW'(outstanding <= FD), 1);
        end
        if (o_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (o_valid === 1'b1 && i_ready === 1'b1) begin
            if (exp_q.size() == 0) fail("spurious_output");
            else check("xfer_data_last", obs, exp_q.pop_front());
            outstanding--;
            if (first_xfer_cyc < 0) first_xfer_cyc = cyc;
            last_xfer_cyc = cyc;
            xfer_cnt++;
        end
        hold_pending = (o_valid === 1'b1) && (i_ready === 1'b0);
        held = obs;
        @(negedge clk2x);
        cyc++;
    endtask

    task automatic do_cmd(input logic [AW-1:0] base, input int len);
        int guard;
        i_cmd_valid = 1'b1;
        i_cmd_base  = base;
        i_cmd_len   = (AW+1)'(len);
        guard = 0;
        while (o_cmd_ready !== 1'b1 && guard < 50) begin
            cycle();
            guard++;
        end
        if (guard >= 50) fail("cmd_ready_timeout");
        cmd_cyc = cyc;
        first_valid_cyc = -1;
        first_xfer_cyc = -1;
        last_xfer_cyc = -1;
        xfer_cnt = 0;
        exp_ra = base;
        for (int i = 0; i < len; i++) begin
            exp_q.push_back({(i == len - 1), DW'(AW'(base + AW'(i)))});
        end
        cycle();
        i_cmd_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles, input bit rand_ready);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            n++;
        end
        i_ready = 1'b1;
        check("drain_complete", DW'(exp_q.size()), 0);
        cycle();
        cycle();
        check("idle_busy", DW'(o_busy), 0);
        check("idle_cmd_ready", DW'(o_cmd_ready), 1);
        check("idle_valid", DW'(o_valid), 0);
    endtask

    task automatic check_reset_state();
        check("rst_cmd_ready", DW'(o_cmd_ready), 0);
        check("rst_re", DW'(o_re), 0);
        check("rst_ra", DW'(o_ra), 0);
        check("rst_valid", DW'(o_valid), 0);
        check("rst_last", DW'(o_last), 0);
        check("rst_busy", DW'(o_busy), 0);
        check("rst_data", DW'(o_data), 0);
    endtask

    initial begin
        // Power-on reset.
        @(negedge clk2x);
        reset = 1'b0;
        cycle();
        cycle();
        check_reset_state();
        reset = 1'b1;
        cycle();
        check("post_rst_cmd_ready", DW'(o_cmd_ready), 1);

        // 1: base 0x010, len 8, consumer always ready.
        i_ready = 1'b1;
        do_cmd(12'h010, 8);
        drain(100, 1'b0);
        check("t1_first_valid_latency", DW'(first_valid_cyc - cmd_cyc), 4);
        check("t1_xfer_count", DW'(xfer_cnt), 8);
        check("t1_no_bubbles", DW'(last_xfer_cyc - first_xfer_cyc), 7);

        // 2: wrap across the top of the address space.
        do_cmd(12'hFFE, 4);
        drain(100, 1'b0);
        check("t2_xfer_count", DW'(xfer_cnt), 4);

        // 3: long command with a randomly stalling consumer.
        do_cmd(12'h123, 64);
        drain(2000, 1'b1);
        check("t3_xfer_count", DW'(xfer_cnt), 64);

        // 4: zero-length command produces nothing.
        do_cmd(12'h020, 0);
        check("t4_ready_next_cycle", DW'(o_cmd_ready), 1);
        for (int i = 0; i < 4; i++) begin
            check("t4_no_re", DW'(o_re), 0);
            check("t4_no_valid", DW'(o_valid), 0);
            cycle();
        end

        // 5: reset with reads in flight, then a fresh command.
        i_ready = 1'b0;
        do_cmd(12'h200, 16);
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        hold_pending = 1'b0;
        exp_q.delete();
        outstanding = 0;
        check_reset_state();
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("t5_no_stale_valid", DW'(o_valid), 0);
            cycle();
        end
        do_cmd(12'h100, 2);
        drain(100, 1'b0);
        check("t5_xfer_count", DW'(xfer_cnt), 2);

        // 6: full-depth command starting mid-array.
        do_cmd(12'h800, 4096);
        drain(6000, 1'b0);
        check("t6_xfer_count", DW'(xfer_cnt), 4096);
        check("t6_no_bubbles", DW'(last_xfer_cyc - first_xfer_cyc), 4095);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uram_stream_reader
